// File: rtl/sys_io_pkg.sv
// rtl/sys_io_pkg.sv - shared constants, FSM states and packet struct for the controller receiver (CONTROLLER_CHECKSUM_EN adds the CSUM state)
package sys_io_pkg;

    // Framing byte that starts every controller packet
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_HUNT = 3'd0,
        ST_BTN  = 3'd1,
        ST_JX   = 3'd2,
`ifdef CONTROLLER_CHECKSUM_EN
        ST_JY   = 3'd3,
        ST_CSUM = 3'd4
`else
        ST_JY   = 3'd3
`endif
    } state_t;

    typedef struct packed {
        logic [7:0] buttons;
        logic [7:0] joystick_x;
        logic [7:0] joystick_y;
    } controller_t;

    // No buttons pressed, both axes centred
    localparam controller_t CONTROLLER_RESET = '{
        buttons:    8'h00,
        joystick_x: 8'h80,
        joystick_y: 8'h80
    };

endpackage

// File: rtl/spi_byte_rx.sv
// rtl/spi_byte_rx.sv - synchronizes the serial clock/data pair and assembles MSB-first bytes
module spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       chip_clk_raw,
    input  logic       chip_data_raw,
    input  logic       clear_bits,
    output logic       clk_edge,
    output logic [2:0] bit_count,
    output logic [7:0] byte_data,
    output logic       byte_done
);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_s;
    logic                   data_s;
    logic                   clk_prev;
    logic [7:0]             shift_q;

    // Multi-flop synchronizers; the raw pins feed nothing but stage 0
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            clk_sync  <= '0;
            data_sync <= '0;
        end else begin
            clk_sync[0]  <= chip_clk_raw;
            data_sync[0] <= chip_data_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                clk_sync[i]  <= clk_sync[i-1];
                data_sync[i] <= data_sync[i-1];
            end
        end
    end

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

    // Previous synchronized clock level for rising-edge detection
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            clk_prev <= 1'b0;
        end else begin
            clk_prev <= clk_s;
        end
    end

    assign clk_edge = clk_s & ~clk_prev;

    // Shift in one bit per edge; an edge wins over a concurrent clear request
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            shift_q   <= 8'h00;
            bit_count <= 3'd0;
            byte_data <= 8'h00;
            byte_done <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (clk_edge) begin
                shift_q   <= {shift_q[6:0], data_s};
                bit_count <= bit_count + 3'd1;
                if (bit_count == 3'd7) begin
                    byte_data <= {shift_q[6:0], data_s};
                    byte_done <= 1'b1;
                end
            end else if (clear_bits) begin
                bit_count <= 3'd0;
            end
        end
    end

endmodule

// File: rtl/controller_spi_rx.sv
// rtl/controller_spi_rx.sv - controller packet framer with idle timeout and atomic commit (CONTROLLER_CHECKSUM_EN enables checksum byte)
module controller_spi_rx
    import sys_io_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       chip_clk_raw,
    input  logic       chip_data_raw,
    output logic [7:0] buttons,
    output logic [7:0] joystick_x,
    output logic [7:0] joystick_y,
    output logic       packet_valid,
    output logic [7:0] last_raw_byte,
    output logic       frame_error
);

    localparam int                IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

    state_t            state;
    state_t            state_next;
    logic              clk_edge;
    logic [2:0]        bit_count;
    logic [7:0]        rx_byte;
    logic              byte_done;
    logic [IDLE_W-1:0] idle_cnt;
    logic              timeout_abort;
    logic              cap_btn;
    logic              cap_jx;
    logic              commit;
    controller_t       commit_value;
    controller_t       committed;
    logic [7:0]        shadow_btn;
    logic [7:0]        shadow_jx;
`ifdef CONTROLLER_CHECKSUM_EN
    logic              cap_jy;
    logic              csum_bad;
    logic [7:0]        shadow_jy;
`endif

    spi_byte_rx #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_byte_rx (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .chip_clk_raw  (chip_clk_raw),
        .chip_data_raw (chip_data_raw),
        .clear_bits    (timeout_abort),
        .clk_edge      (clk_edge),
        .bit_count     (bit_count),
        .byte_data     (rx_byte),
        .byte_done     (byte_done)
    );

    // Idle counter: cleared by every serial clock edge, saturates at the timeout
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            idle_cnt <= '0;
        end else if (clk_edge) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Abort only when something is in flight; a same-cycle edge keeps the transfer alive
    assign timeout_abort = (idle_cnt == IDLE_MAX) && !clk_edge &&
                           ((bit_count != 3'd0) || (state != ST_HUNT));

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= ST_HUNT;
        end else begin
            state <= state_next;
        end
    end

    // Next state, shadow capture strobes and commit decision
    always_comb begin
        state_next   = state;
        cap_btn      = 1'b0;
        cap_jx       = 1'b0;
        commit       = 1'b0;
`ifdef CONTROLLER_CHECKSUM_EN
        cap_jy       = 1'b0;
        csum_bad     = 1'b0;
        commit_value = '{buttons: shadow_btn, joystick_x: shadow_jx, joystick_y: shadow_jy};
`else
        commit_value = '{buttons: shadow_btn, joystick_x: shadow_jx, joystick_y: rx_byte};
`endif
        if (byte_done) begin
            case (state)
                ST_HUNT: begin
                    if (rx_byte == SYNC_BYTE) begin
                        state_next = ST_BTN;
                    end
                end
                ST_BTN: begin
                    cap_btn    = 1'b1;
                    state_next = ST_JX;
                end
                ST_JX: begin
                    cap_jx     = 1'b1;
                    state_next = ST_JY;
                end
`ifdef CONTROLLER_CHECKSUM_EN
                ST_JY: begin
                    cap_jy     = 1'b1;
                    state_next = ST_CSUM;
                end
                ST_CSUM: begin
                    if (rx_byte == (shadow_btn ^ shadow_jx ^ shadow_jy)) begin
                        commit = 1'b1;
                    end else begin
                        csum_bad = 1'b1;
                    end
                    state_next = ST_HUNT;
                end
`else
                ST_JY: begin
                    commit     = 1'b1;
                    state_next = ST_HUNT;
                end
`endif
                default: begin
                    state_next = ST_HUNT;
                end
            endcase
        end else if (timeout_abort) begin
            state_next = ST_HUNT;
        end
    end

    // Shadow registers hold the packet until it is complete
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            shadow_btn <= 8'h00;
            shadow_jx  <= 8'h00;
`ifdef CONTROLLER_CHECKSUM_EN
            shadow_jy  <= 8'h00;
`endif
        end else begin
            if (cap_btn) begin
                shadow_btn <= rx_byte;
            end
            if (cap_jx) begin
                shadow_jx <= rx_byte;
            end
`ifdef CONTROLLER_CHECKSUM_EN
            if (cap_jy) begin
                shadow_jy <= rx_byte;
            end
`endif
        end
    end

    // Visible outputs: whole-packet commit, raw byte mirror and status pulses
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            committed     <= CONTROLLER_RESET;
            last_raw_byte <= 8'h00;
            packet_valid  <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            packet_valid <= commit;
`ifdef CONTROLLER_CHECKSUM_EN
            frame_error  <= timeout_abort | csum_bad;
`else
            frame_error  <= timeout_abort;
`endif
            if (commit) begin
                committed <= commit_value;
            end
            if (byte_done) begin
                last_raw_byte <= rx_byte;
            end
        end
    end

    assign buttons    = committed.buttons;
    assign joystick_x = committed.joystick_x;
    assign joystick_y = committed.joystick_y;

endmodule

// File: tb/tb_controller_spi_rx.sv
// tb/tb_controller_spi_rx.sv - randomized self-checking bench for controller_spi_rx with a packet-level reference model
module tb_controller_spi_rx;

    localparam int TIMEOUT = 200;
`ifdef CONTROLLER_CHECKSUM_EN
    localparam int PKT_LEN = 4;
`else
    localparam int PKT_LEN = 3;
`endif

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       chip_clk_raw = 1'b0;
    logic       chip_data_raw = 1'b0;
    logic [7:0] buttons;
    logic [7:0] joystick_x;
    logic [7:0] joystick_y;
    logic       packet_valid;
    logic [7:0] last_raw_byte;
    logic       frame_error;

    controller_spi_rx #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .chip_clk_raw  (chip_clk_raw),
        .chip_data_raw (chip_data_raw),
        .buttons       (buttons),
        .joystick_x    (joystick_x),
        .joystick_y    (joystick_y),
        .packet_valid  (packet_valid),
        .last_raw_byte (last_raw_byte),
        .frame_error   (frame_error)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int pv_seen = 0;
    int fe_seen = 0;

    always @(negedge clk_in) begin
        if (packet_valid === 1'b1) pv_seen++;
        if (frame_error === 1'b1) fe_seen++;
    end

    // Reference model: packet-level view of the byte stream
    bit         m_hunting = 1'b1;
    bit         m_partial = 1'b0;
    logic [7:0] m_pkt[$];
    logic [7:0] exp_btn = 8'h00;
    logic [7:0] exp_x = 8'h80;
    logic [7:0] exp_y = 8'h80;
    logic [7:0] exp_raw = 8'h00;
    int         exp_pv = 0;
    int         exp_fe = 0;

    task automatic model_byte(input logic [7:0] b);
        exp_raw = b;
        if (m_hunting) begin
            if (b == 8'hA5) begin
                m_hunting = 1'b0;
                m_pkt.delete();
            end
        end else begin
            m_pkt.push_back(b);
            if (m_pkt.size() == PKT_LEN) begin
                if (PKT_LEN == 4 && b != (m_pkt[0] ^ m_pkt[1] ^ m_pkt[2])) begin
                    exp_fe++;
                end else begin
                    exp_btn = m_pkt[0];
                    exp_x   = m_pkt[1];
                    exp_y   = m_pkt[2];
                    exp_pv++;
                end
                m_hunting = 1'b1;
            end
        end
    endtask

    task automatic model_idle();
        if (!m_hunting || m_partial) exp_fe++;
        m_hunting = 1'b1;
        m_partial = 1'b0;
    endtask

    task automatic model_reset();
        m_hunting = 1'b1;
        m_partial = 1'b0;
        m_pkt.delete();
        exp_btn = 8'h00;
        exp_x   = 8'h80;
        exp_y   = 8'h80;
        exp_raw = 8'h00;
    endtask

    // Serial drivers
    task automatic send_bit(input logic b);
        @(posedge clk_in); #1;
        chip_data_raw = b;
        repeat (4) @(posedge clk_in);
        #1 chip_clk_raw = 1'b1;
        repeat (4) @(posedge clk_in);
        #1 chip_clk_raw = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        repeat (4) @(posedge clk_in);
        #1;
        model_byte(b);
    endtask

    task automatic go_idle();
        repeat (TIMEOUT + 30) @(posedge clk_in);
        #1;
        model_idle();
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        checks++; if (buttons !== 8'h00) begin errors++; $display("FAIL reset_buttons: got %h expected 00", buttons); end
        checks++; if (joystick_x !== 8'h80) begin errors++; $display("FAIL reset_jx: got %h expected 80", joystick_x); end
        checks++; if (joystick_y !== 8'h80) begin errors++; $display("FAIL reset_jy: got %h expected 80", joystick_y); end
        checks++; if (last_raw_byte !== 8'h00) begin errors++; $display("FAIL reset_raw: got %h expected 00", last_raw_byte); end
        checks++; if ({packet_valid, frame_error} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b expected 00", {packet_valid, frame_error}); end
        #1 rst_in = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_in);
    endtask

    task automatic test_basic();
        logic [7:0] seq [4] = '{8'hA5, 8'h12, 8'h34, 8'h56};
        for (int i = 0; i < 4; i++) send_byte(seq[i]);
        checks++; if ({buttons, joystick_x, joystick_y} !== {exp_btn, exp_x, exp_y}) begin errors++; $display("FAIL basic_outputs: got %h expected %h", {buttons, joystick_x, joystick_y}, {exp_btn, exp_x, exp_y}); end
        checks++; if (pv_seen !== exp_pv) begin errors++; $display("FAIL basic_pv_count: got %0d expected %0d", pv_seen, exp_pv); end
        checks++; if (last_raw_byte !== exp_raw) begin errors++; $display("FAIL basic_raw: got %h expected %h", last_raw_byte, exp_raw); end
    endtask

    task automatic test_hunt();
        logic [7:0] seq [6] = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h02, 8'h03};
        for (int i = 0; i < 6; i++) begin
            send_byte(seq[i]);
            checks++; if (last_raw_byte !== exp_raw) begin errors++; $display("FAIL hunt_raw[%0d]: got %h expected %h", i, last_raw_byte, exp_raw); end
        end
        checks++; if ({buttons, joystick_x, joystick_y} !== {exp_btn, exp_x, exp_y}) begin errors++; $display("FAIL hunt_outputs: got %h expected %h", {buttons, joystick_x, joystick_y}, {exp_btn, exp_x, exp_y}); end
        checks++; if (pv_seen !== exp_pv) begin errors++; $display("FAIL hunt_pv_count: got %0d expected %0d", pv_seen, exp_pv); end
    endtask

    task automatic test_timeout_packet();
        logic [7:0] seq [4] = '{8'hA5, 8'h07, 8'h08, 8'h09};
        send_byte(8'hA5);
        send_byte(8'h12);
        go_idle();
        checks++; if (fe_seen !== exp_fe) begin errors++; $display("FAIL tmo_pkt_fe: got %0d expected %0d", fe_seen, exp_fe); end
        checks++; if ({buttons, joystick_x, joystick_y} !== {exp_btn, exp_x, exp_y}) begin errors++; $display("FAIL tmo_pkt_hold: got %h expected %h", {buttons, joystick_x, joystick_y}, {exp_btn, exp_x, exp_y}); end
        for (int i = 0; i < 4; i++) send_byte(seq[i]);
        checks++; if ({buttons, joystick_x, joystick_y} !== {exp_btn, exp_x, exp_y}) begin errors++; $display("FAIL tmo_pkt_next: got %h expected %h", {buttons, joystick_x, joystick_y}, {exp_btn, exp_x, exp_y}); end
        checks++; if (pv_seen !== exp_pv) begin errors++; $display("FAIL tmo_pkt_pv: got %0d expected %0d", pv_seen, exp_pv); end
    endtask

    task automatic test_timeout_bits();
        logic [7:0] seq [4] = '{8'hA5, 8'h3C, 8'hC3, 8'h5A};
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        m_partial = 1'b1;
        go_idle();
        checks++; if (fe_seen !== exp_fe) begin errors++; $display("FAIL tmo_bits_fe: got %0d expected %0d", fe_seen, exp_fe); end
        for (int i = 0; i < 4; i++) send_byte(seq[i]);
        checks++; if (last_raw_byte !== exp_raw) begin errors++; $display("FAIL tmo_bits_raw: got %h expected %h", last_raw_byte, exp_raw); end
        checks++; if ({buttons, joystick_x, joystick_y} !== {exp_btn, exp_x, exp_y}) begin errors++; $display("FAIL tmo_bits_outputs: got %h expected %h", {buttons, joystick_x, joystick_y}, {exp_btn, exp_x, exp_y}); end
        go_idle();
        checks++; if (fe_seen !== exp_fe) begin errors++; $display("FAIL idle_hunt_no_fe: got %0d expected %0d", fe_seen, exp_fe); end
    endtask

    task automatic test_sync_as_payload();
        logic [7:0] seq [PKT_LEN+1];
        seq[0] = 8'hA5;
        seq[1] = 8'hA5;
        seq[2] = 8'hA5;
        seq[3] = 8'h44;
        if (PKT_LEN == 4) seq[PKT_LEN] = 8'hA5 ^ 8'hA5 ^ 8'h44;
        for (int i = 0; i <= PKT_LEN; i++) send_byte(seq[i]);
        checks++; if ({buttons, joystick_x, joystick_y} !== {exp_btn, exp_x, exp_y}) begin errors++; $display("FAIL sync_payload: got %h expected %h", {buttons, joystick_x, joystick_y}, {exp_btn, exp_x, exp_y}); end
        checks++; if (pv_seen !== exp_pv) begin errors++; $display("FAIL sync_payload_pv: got %0d expected %0d", pv_seen, exp_pv); end
    endtask

`ifdef CONTROLLER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] good [5] = '{8'hA5, 8'h01, 8'h02, 8'h04, 8'h07};
        logic [7:0] bad  [5] = '{8'hA5, 8'h09, 8'h0A, 8'h0B, 8'h00};
        for (int i = 0; i < 5; i++) send_byte(good[i]);
        checks++; if ({buttons, joystick_x, joystick_y} !== {exp_btn, exp_x, exp_y}) begin errors++; $display("FAIL csum_good: got %h expected %h", {buttons, joystick_x, joystick_y}, {exp_btn, exp_x, exp_y}); end
        for (int i = 0; i < 5; i++) send_byte(bad[i]);
        checks++; if ({buttons, joystick_x, joystick_y} !== {exp_btn, exp_x, exp_y}) begin errors++; $display("FAIL csum_bad_hold: got %h expected %h", {buttons, joystick_x, joystick_y}, {exp_btn, exp_x, exp_y}); end
        checks++; if (fe_seen !== exp_fe) begin errors++; $display("FAIL csum_bad_fe: got %0d expected %0d", fe_seen, exp_fe); end
    endtask
`endif

    task automatic test_reset_mid();
        logic [7:0] seq [PKT_LEN+1];
        send_byte(8'hA5);
        send_byte(8'h11);
        send_byte(8'h22);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #2 rst_in = 1'b1;
        #1;
        checks++; if ({buttons, joystick_x, joystick_y} !== 24'h008080) begin errors++; $display("FAIL rst_mid_outputs: got %h expected 008080", {buttons, joystick_x, joystick_y}); end
        checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL rst_mid_fe: got %b expected 0", frame_error); end
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;
        model_reset();
        go_idle();
        checks++; if (fe_seen !== exp_fe) begin errors++; $display("FAIL rst_mid_no_fe: got %0d expected %0d", fe_seen, exp_fe); end
        seq[0] = 8'hA5;
        seq[1] = 8'h61;
        seq[2] = 8'h62;
        seq[3] = 8'h63;
        if (PKT_LEN == 4) seq[PKT_LEN] = 8'h61 ^ 8'h62 ^ 8'h63;
        for (int i = 0; i <= PKT_LEN; i++) send_byte(seq[i]);
        checks++; if ({buttons, joystick_x, joystick_y} !== {exp_btn, exp_x, exp_y}) begin errors++; $display("FAIL rst_mid_next: got %h expected %h", {buttons, joystick_x, joystick_y}, {exp_btn, exp_x, exp_y}); end
        checks++; if (pv_seen !== exp_pv) begin errors++; $display("FAIL rst_mid_pv: got %0d expected %0d", pv_seen, exp_pv); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                go_idle();
            end else begin
                if ($urandom_range(0, 3) == 0) b = 8'hA5;
                else if (PKT_LEN == 4 && m_pkt.size() == 3 && !m_hunting && $urandom_range(0, 1) == 1)
                    b = m_pkt[0] ^ m_pkt[1] ^ m_pkt[2];
                else b = 8'($urandom);
                send_byte(b);
                checks++; if (last_raw_byte !== exp_raw) begin errors++; $display("FAIL rand_raw[%0d]: got %h expected %h", i, last_raw_byte, exp_raw); end
            end
            checks++; if ({buttons, joystick_x, joystick_y} !== {exp_btn, exp_x, exp_y}) begin errors++; $display("FAIL rand_outputs[%0d]: got %h expected %h", i, {buttons, joystick_x, joystick_y}, {exp_btn, exp_x, exp_y}); end
            checks++; if ({pv_seen, fe_seen} !== {exp_pv, exp_fe}) begin errors++; $display("FAIL rand_pulses[%0d]: got pv %0d fe %0d expected pv %0d fe %0d", i, pv_seen, fe_seen, exp_pv, exp_fe); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hunt();
        test_timeout_packet();
        test_timeout_bits();
        test_sync_as_payload();
`ifdef CONTROLLER_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
